// File: rtl/mem_store_ser.sv
// mem_store_ser: byte-serial store engine (SB/SH/SW), LSB first at ascending addresses on the grant-gated 8-bit RAM port; done_o pulses on completion
module mem_store_ser #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid_i,
  output logic              st_ready_o,
  input  logic [1:0]        st_size_i,
  input  logic [ADDR_W-1:0] st_addr_i,
  input  logic [31:0]       st_data_i,
  input  logic              gnt_RAM_i,
  output logic              we_RAM_o,
  output logic [ADDR_W-1:0] waddr_RAM_o,
  output logic [7:0]        wdata_RAM_o,
  output logic              done_o,
  output logic              busy_o
);
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [31:0] data;
  logic [1:0]  last, k;
  assign st_ready_o = state == IDLE;
  assign busy_o = state != IDLE;
  always_comb
    state_n = state == IDLE  ? (st_valid_i ? (st_size_i == 2'b11 ? DONE : WRITE) : IDLE) :
              state == WRITE ? (gnt_RAM_i && k == last ? DONE : WRITE) : IDLE;
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (!rst) begin
      k <= 2'd0;
      last <= 2'd0;
      data <= 32'd0;
      we_RAM_o <= 1'b0;
      waddr_RAM_o <= '0;
      wdata_RAM_o <= 8'd0;
      done_o <= 1'b0;
    end else begin
      done_o <= state_n == DONE;
      we_RAM_o <= state_n == WRITE;
      if (state == IDLE && st_valid_i && st_size_i != 2'b11) begin
        k <= 2'd0;
        last <= st_size_i == 2'b00 ? 2'd0 : st_size_i == 2'b01 ? 2'd1 : 2'd3;
        data <= st_data_i;
        waddr_RAM_o <= st_addr_i;
        wdata_RAM_o <= st_data_i[7:0];
      end else if (state == WRITE && gnt_RAM_i && k != last) begin
        k <= k + 2'd1;
        data <= data >> 8;
        waddr_RAM_o <= waddr_RAM_o + ADDR_W'(1);
        wdata_RAM_o <= data[15:8];
      end
    end
endmodule

// File: tb/tb_mem_store_ser.sv
// tb_mem_store_ser: queue-model comparison every cycle plus literal write/done logs per store
module tb_mem_store_ser;
  logic        clk = 0, rst = 0, valid = 0, gnt = 0;
  logic [1:0]  size = 0;
  logic [31:0] addr = 0, data = 0;
  logic        ready, we, done, busy;
  logic [31:0] waddr;
  logic [7:0]  wdata;
  mem_store_ser #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .st_valid_i(valid), .st_ready_o(ready), .st_size_i(size),
    .st_addr_i(addr), .st_data_i(data), .gnt_RAM_i(gnt), .we_RAM_o(we),
    .waddr_RAM_o(waddr), .wdata_RAM_o(wdata), .done_o(done), .busy_o(busy)
  );
  always #5 clk = ~clk;
  int ncmp = 0, nerr = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  int cyc = 0, acc = 0, acc_prev = 0, mode = 0;
  bit mvalid = 0;
  logic [39:0] pend[$];
  logic        e_we = 0, e_done = 0;
  logic [31:0] e_addr = 0;
  logic [7:0]  e_data = 0;
  logic [31:0] la[16];
  logic [7:0]  ld[16];
  int          lr[16];
  int          nlog = 0, nd = 0, drel = 0;
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      mvalid = 1;
      mode = 0;
      pend.delete();
      e_we = 0; e_addr = 0; e_data = 0; e_done = 0;
    end else if (mode == 0) begin
      e_done = 0;
      if (valid) begin
        acc_prev = acc; acc = cyc; nlog = 0; nd = 0; drel = 0;
        if (size == 2'b11) begin
          mode = 2; e_done = 1;
        end else begin
          for (int i = 0; i < (size == 0 ? 1 : size == 1 ? 2 : 4); i++)
            pend.push_back({addr + 32'(i), data[8*i +: 8]});
          mode = 1; e_we = 1;
          {e_addr, e_data} = pend[0];
        end
      end
    end else if (mode == 1) begin
      if (gnt) begin
        void'(pend.pop_front());
        if (pend.size() == 0) begin
          e_we = 0; mode = 2; e_done = 1;
        end else {e_addr, e_data} = pend[0];
      end
    end else begin
      e_done = 0; mode = 0;
    end
  end
  always @(negedge clk) if (mvalid) begin
    chk("ready", ready, mode == 0);
    chk("busy", busy, mode != 0);
    chk("we", we, e_we);
    chk("waddr", waddr, e_addr);
    chk("wdata", wdata, e_data);
    chk("done", done, e_done);
    if (we && gnt && nlog < 16) begin
      la[nlog] = waddr; ld[nlog] = wdata; lr[nlog] = cyc - acc + 1; nlog++;
    end
    if (done) begin nd++; drel = cyc - acc + 1; end
  end
  task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d, input logic [15:0] gm);
    valid = 1; size = sz; addr = a; data = d; gnt = 1;
    @(posedge clk); #1;
    valid = 0; addr = 32'hDEADBEEF; data = 32'hCAFEF00D;
    for (int c = 1; c <= 7; c++) begin
      gnt = gm[c];
      @(posedge clk); #1;
    end
  endtask
  task automatic chk_wr(input int i, input logic [31:0] a, input logic [7:0] d, input int r);
    chk($sformatf("log%0d_addr", i), la[i], a);
    chk($sformatf("log%0d_data", i), {24'd0, ld[i]}, {24'd0, d});
    chk($sformatf("log%0d_cycle", i), lr[i], r);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1); chk("rst_busy", busy, 0); chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0); chk("rst_wdata", wdata, 0); chk("rst_done", done, 0);
    rst = 1;
    @(posedge clk); #1;
    do_store(2'b10, 32'h00001000, 32'hA1B2C3D4, 16'hFFFF);
    chk("sw_nwrites", nlog, 4);
    chk_wr(0, 32'h1000, 8'hD4, 1); chk_wr(1, 32'h1001, 8'hC3, 2);
    chk_wr(2, 32'h1002, 8'hB2, 3); chk_wr(3, 32'h1003, 8'hA1, 4);
    chk("sw_ndone", nd, 1); chk("sw_done_cycle", drel, 5);
    do_store(2'b01, 32'h00000020, 32'hFFFF5A6B, 16'hFFF5);
    chk("sh_nwrites", nlog, 2);
    chk_wr(0, 32'h20, 8'h6B, 2); chk_wr(1, 32'h21, 8'h5A, 4);
    chk("sh_ndone", nd, 1); chk("sh_done_cycle", drel, 5);
    do_store(2'b10, 32'hFFFFFFFE, 32'h11223344, 16'hFFFF);
    chk("wrap_nwrites", nlog, 4);
    chk_wr(0, 32'hFFFFFFFE, 8'h44, 1); chk_wr(1, 32'hFFFFFFFF, 8'h33, 2);
    chk_wr(2, 32'h00000000, 8'h22, 3); chk_wr(3, 32'h00000001, 8'h11, 4);
    valid = 1; size = 2'b00; addr = 32'h7; data = 32'h000000EE; gnt = 1;
    @(posedge clk); #1;
    addr = 32'h8; data = 32'h00000099;
    repeat (2) begin @(posedge clk); #1; end
    chk("sb_nwrites", nlog, 1);
    chk_wr(0, 32'h7, 8'hEE, 1);
    chk("sb_done_cycle", drel, 2);
    @(posedge clk); #1;
    valid = 0;
    chk("sb_reaccept_gap", acc - acc_prev, 3);
    repeat (4) begin @(posedge clk); #1; end
    chk("sb2_nwrites", nlog, 1);
    chk_wr(0, 32'h8, 8'h99, 1);
    chk("sb2_done_cycle", drel, 2);
    valid = 1; size = 2'b10; addr = 32'h300; data = 32'h01020304; gnt = 1;
    @(posedge clk); #1;
    valid = 0;
    rst = 0; #2; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    rst = 1;
    chk("rst_mid_we", we, 0); chk("rst_mid_ready", ready, 1);
    chk("rst_mid_waddr", waddr, 0);
    repeat (5) begin @(posedge clk); #1; end
    chk("rst_mid_nwrites", nlog, 2);
    chk_wr(0, 32'h300, 8'h04, 1); chk_wr(1, 32'h301, 8'h03, 2);
    chk("rst_mid_ndone", nd, 0);
    do_store(2'b11, 32'h400, 32'h55667788, 16'hFFFF);
    chk("rsv_nwrites", nlog, 0);
    chk("rsv_ndone", nd, 1); chk("rsv_done_cycle", drel, 1);
    chk("rsv_waddr_hold", waddr, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
